// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared sizing and types for the general register file and the read/write
// logic that feeds it.
//   DATA_WIDTH : width of each register and every data port
//   SEL_WIDTH  : width of every register select
//   NUM_REGS   : register count, tied to SEL_WIDTH so selects never go out of range
//   reg_sel_t  : register select type
//   reg_data_t : register data type
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int SEL_WIDTH  = 3;
    localparam int NUM_REGS   = 2 ** SEL_WIDTH;

    typedef logic [SEL_WIDTH-1:0]  reg_sel_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/register_file_if.sv
// ---------------------------------------------------------------------------
// register_file_if
// Bundles the write request, the three read ports and the commit status of
// the register file.
//   master : read/write logic side (drives requests and selects)
//   slave  : register file side (returns read data and commit status)
// Signals:
//   hold, write_enable, write_select, write_data   write request
//   read_select_1/2, read_data_1/2                 forwarded operand reads
//   dbg_select, dbg_data                           array-only debug read
//   commit_pulse, commit_select                    buffer commit status
// ---------------------------------------------------------------------------
interface register_file_if;
    import regfile_pkg::*;

    logic      hold;
    logic      write_enable;
    reg_sel_t  write_select;
    reg_data_t write_data;
    reg_sel_t  read_select_1;
    reg_sel_t  read_select_2;
    reg_sel_t  dbg_select;
    reg_data_t read_data_1;
    reg_data_t read_data_2;
    reg_data_t dbg_data;
    logic      commit_pulse;
    reg_sel_t  commit_select;

    modport master (
        output hold, write_enable, write_select, write_data,
        output read_select_1, read_select_2, dbg_select,
        input  read_data_1, read_data_2, dbg_data,
        input  commit_pulse, commit_select
    );

    modport slave (
        input  hold, write_enable, write_select, write_data,
        input  read_select_1, read_select_2, dbg_select,
        output read_data_1, read_data_2, dbg_data,
        output commit_pulse, commit_select
    );

endinterface

// File: rtl/regfile_forward_mux.sv
// ---------------------------------------------------------------------------
// regfile_forward_mux
// One read port of the register file: returns the write-back buffer contents
// when the buffer holds a pending write to the selected register, otherwise
// the array value.
//   wb_valid    : buffer holds a pending write
//   wb_sel      : destination of the pending write
//   wb_data     : value of the pending write
//   read_select : register being read
//   array_data  : array contents of read_select
//   read_data   : forwarded read value
// ---------------------------------------------------------------------------
module regfile_forward_mux
    import regfile_pkg::*;
(
    input  logic      wb_valid,
    input  reg_sel_t  wb_sel,
    input  reg_data_t wb_data,
    input  reg_sel_t  read_select,
    input  reg_data_t array_data,
    output reg_data_t read_data
);

    assign read_data = (wb_valid && (wb_sel == read_select)) ? wb_data : array_data;

endmodule

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
// 8 x 8-bit general register array. Writes land in a one-entry write-back
// buffer and commit to the array on the following edge; the two operand read
// ports forward the buffered value so a result is readable the cycle after it
// was written. The debug port sees the array only.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset; clears the array and drops any
//           pending buffered write
//   bus   : register_file_if slave port (requests, reads, commit status)
// ---------------------------------------------------------------------------
module register_file
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    register_file_if.slave  bus
);

    reg_data_t regs [NUM_REGS];

    logic      wb_valid;
    reg_sel_t  wb_sel;
    reg_data_t wb_data;
    logic      commit_pulse_q;
    reg_sel_t  commit_select_q;

    // The commit of the old buffer entry and the load of the new request
    // happen on the same edge, so back-to-back writes to one register never
    // lose the older value. A held request is dropped, not queued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wb_valid        <= 1'b0;
            wb_sel          <= '0;
            wb_data         <= '0;
            commit_pulse_q  <= 1'b0;
            commit_select_q <= '0;
        end else begin
            if (wb_valid) begin
                regs[wb_sel]    <= wb_data;
                commit_pulse_q  <= 1'b1;
                commit_select_q <= wb_sel;
            end else begin
                commit_pulse_q  <= 1'b0;
            end

            if (bus.write_enable && !bus.hold) begin
                wb_valid <= 1'b1;
                wb_sel   <= bus.write_select;
                wb_data  <= bus.write_data;
            end else begin
                wb_valid <= 1'b0;
            end
        end
    end

    regfile_forward_mux u_fwd_1 (
        .wb_valid    (wb_valid),
        .wb_sel      (wb_sel),
        .wb_data     (wb_data),
        .read_select (bus.read_select_1),
        .array_data  (regs[bus.read_select_1]),
        .read_data   (bus.read_data_1)
    );

    regfile_forward_mux u_fwd_2 (
        .wb_valid    (wb_valid),
        .wb_sel      (wb_sel),
        .wb_data     (wb_data),
        .read_select (bus.read_select_2),
        .array_data  (regs[bus.read_select_2]),
        .read_data   (bus.read_data_2)
    );

    assign bus.dbg_data      = regs[bus.dbg_select];
    assign bus.commit_pulse  = commit_pulse_q;
    assign bus.commit_select = commit_select_q;

endmodule
